dsm_hop_sequencer: RTL

DSM_HOP_SEQUENCER -- requirements
Module: dsm_hop_sequencer

---
 rtl/dsm_hop_sequencer_if.sv | 33 +++
 rtl/dsm_hop_sequencer.sv | 138 +++++++++++++
 2 files changed

// File: rtl/dsm_hop_sequencer_if.sv
// Hop-sequencer bus: table configuration, run control, and the registered words that drive the DSM core.
interface dsm_hop_sequencer_if #(
    parameter int NUM_ENTRIES = 4,
    parameter int DWELL_W     = 8
);
    localparam int AW = $clog2(NUM_ENTRIES);

    logic               cfg_we;
    logic [AW-1:0]      cfg_addr;
    logic [3:0]         cfg_int;
    logic [15:0]        cfg_frac;
    logic [DWELL_W-1:0] cfg_dwell;
    logic               start;
    logic               stop;
    logic               loop_en;
    logic [3:0]         core_in_i;
    logic [15:0]        core_in_f;
    logic               core_rst_n;
    logic               out_valid;
    logic               busy;
    logic [AW-1:0]      entry_idx;
    logic               done;

    modport master (
        output cfg_we, cfg_addr, cfg_int, cfg_frac, cfg_dwell, start, stop, loop_en,
        input  core_in_i, core_in_f, core_rst_n, out_valid, busy, entry_idx, done
    );

    modport slave (
        input  cfg_we, cfg_addr, cfg_int, cfg_frac, cfg_dwell, start, stop, loop_en,
        output core_in_i, core_in_f, core_rst_n, out_valid, busy, entry_idx, done
    );
endinterface

// File: rtl/dsm_hop_sequencer.sv
// Steps a DSM core through a hop table: clear, then per entry SETTLE_CYC blanked cycles and D valid cycles.
// All outputs registered (one cycle from inputs); no backpressure, stop aborts to IDLE on the next edge.
module dsm_hop_sequencer #(
    parameter int NUM_ENTRIES = 4,
    parameter int DWELL_W     = 8,
    parameter int SETTLE_CYC  = 2
) (
    input logic               clk,
    input logic               rst_n,
    dsm_hop_sequencer_if.slave hop
);
    localparam int AW = $clog2(NUM_ENTRIES);
    localparam int SW = $clog2(SETTLE_CYC + 1);
    localparam int CW = (DWELL_W > SW) ? DWELL_W : SW;
    localparam logic [AW-1:0] LAST    = AW'(NUM_ENTRIES - 1);
    localparam logic [AW-1:0] IDX_ONE = AW'(1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [CW-1:0] SETTLE_LOAD = CW'(SETTLE_CYC - 1);

    typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_SETTLE, S_DWELL, S_DONE} state_t;

    state_t             state, state_nxt;
    logic [CW-1:0]      cnt, cnt_nxt;
    logic [AW-1:0]      idx_nxt;
    logic [3:0]         ci_nxt;
    logic [15:0]        cf_nxt;
    logic [3:0]         wr_int;
    logic [DWELL_W-1:0] wr_dwell;

    logic [3:0]         tbl_int   [NUM_ENTRIES];
    logic [15:0]        tbl_frac  [NUM_ENTRIES];
    logic [DWELL_W-1:0] tbl_dwell [NUM_ENTRIES];

    // Integer word kept inside the range the core's modulus can realise.
    always_comb begin
        wr_int = hop.cfg_int;
        if (hop.cfg_int < 4'd3)
            wr_int = 4'd3;
        else if (hop.cfg_int > 4'd11)
            wr_int = 4'd11;
        wr_dwell = (hop.cfg_dwell == '0) ? DWELL_W'(1) : hop.cfg_dwell;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                tbl_int[i]   <= 4'd3;
                tbl_frac[i]  <= '0;
                tbl_dwell[i] <= DWELL_W'(1);
            end
        end else if (state == S_IDLE && hop.cfg_we) begin
            tbl_int[hop.cfg_addr]   <= wr_int;
            tbl_frac[hop.cfg_addr]  <= hop.cfg_frac;
            tbl_dwell[hop.cfg_addr] <= wr_dwell;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        idx_nxt   = hop.entry_idx;
        ci_nxt    = hop.core_in_i;
        cf_nxt    = hop.core_in_f;
        if (state != S_IDLE && hop.stop) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (hop.start && !hop.stop) begin
                        state_nxt = S_CLEAR;
                        idx_nxt   = '0;
                    end
                end
                S_CLEAR: begin
                    state_nxt = S_SETTLE;
                    cnt_nxt   = SETTLE_LOAD;
                    ci_nxt    = tbl_int[hop.entry_idx];
                    cf_nxt    = tbl_frac[hop.entry_idx];
                end
                S_SETTLE: begin
                    if (cnt == '0) begin
                        state_nxt = S_DWELL;
                        cnt_nxt   = CW'(tbl_dwell[hop.entry_idx]) - CNT_ONE;
                    end else begin
                        cnt_nxt = cnt - CNT_ONE;
                    end
                end
                S_DWELL: begin
                    if (cnt == '0) begin
                        if (hop.entry_idx != LAST || hop.loop_en) begin
                            idx_nxt   = (hop.entry_idx == LAST) ? '0 : hop.entry_idx + IDX_ONE;
                            state_nxt = S_SETTLE;
                            cnt_nxt   = SETTLE_LOAD;
                            ci_nxt    = tbl_int[idx_nxt];
                            cf_nxt    = tbl_frac[idx_nxt];
                        end else begin
                            state_nxt = S_DONE;
                        end
                    end else begin
                        cnt_nxt = cnt - CNT_ONE;
                    end
                end
                S_DONE:  state_nxt = S_IDLE;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    // Status flags are decoded from the next state so each one is a flop, not a decode of state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt            <= '0;
            hop.entry_idx  <= '0;
            hop.core_in_i  <= '0;
            hop.core_in_f  <= '0;
            hop.core_rst_n <= 1'b0;
            hop.busy       <= 1'b0;
            hop.out_valid  <= 1'b0;
            hop.done       <= 1'b0;
        end else begin
            cnt            <= cnt_nxt;
            hop.entry_idx  <= idx_nxt;
            hop.core_in_i  <= ci_nxt;
            hop.core_in_f  <= cf_nxt;
            hop.core_rst_n <= (state_nxt != S_CLEAR);
            hop.busy       <= (state_nxt != S_IDLE);
            hop.out_valid  <= (state_nxt == S_DWELL);
            hop.done       <= (state_nxt == S_DONE);
        end
    end
endmodule
